// File: rtl/spectrum_pkg.sv
// spectrum_pkg: shared constants, the bar-builder state encoding and the
// peak-decay helper used by spectrum_bar_builder.
//   NUM_BARS     number of published bars
//   BAR_W        width of one bar value
//   BAR_MAX      largest bar value (magnitudes saturate here)
//   spec_state_t COLLECT / UPDATE / PUBLISH / GUARD
//   decay_step   one frame of decay applied to a held bar
package spectrum_pkg;

  localparam int NUM_BARS = 16;
  localparam int BAR_W = 16;
  localparam logic [BAR_W-1:0] BAR_MAX = 16'h7FFF;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    UPDATE  = 2'd1,
    PUBLISH = 2'd2,
    GUARD   = 2'd3
  } spec_state_t;

  // bar - max(bar >> shift, 1) for a nonzero bar, 0 for a zero bar.
  // The decrement never exceeds the bar itself, so the result cannot wrap.
  function automatic logic [BAR_W-1:0] decay_step(input logic [BAR_W-1:0] bar,
                                                  input int unsigned shift);
    logic [BAR_W-1:0] dec;
    dec = bar >> shift;
    if ((dec == 16'h0000) && (bar != 16'h0000)) begin
      dec = 16'h0001;
    end else begin
      dec = dec;
    end
    return bar - dec;
  endfunction

endpackage

// File: rtl/bin_magnitude.sv
// bin_magnitude: combinational |re| + |im| magnitude estimate, saturated to
// BAR_MAX. Shared by the bar builder and the FFT debug path.
//   i_re  signed Q1.15 real part
//   i_im  signed Q1.15 imaginary part
//   o_mag saturated magnitude, 0..0x7FFF
module bin_magnitude
  import spectrum_pkg::*;
(
  input  logic [15:0]      i_re,
  input  logic [15:0]      i_im,
  output logic [BAR_W-1:0] o_mag
);

  logic [16:0] w_re_abs;
  logic [16:0] w_im_abs;
  logic [17:0] w_sum;

  // Absolute values are 17 bits wide so that |-32768| = 32768 is exact.
  always_comb begin
    if (i_re[15]) begin
      w_re_abs = 17'd0 - {i_re[15], i_re};
    end else begin
      w_re_abs = {1'b0, i_re};
    end
    if (i_im[15]) begin
      w_im_abs = 17'd0 - {i_im[15], i_im};
    end else begin
      w_im_abs = {1'b0, i_im};
    end
  end

  // Sum and saturate to the bar range.
  always_comb begin
    w_sum = {1'b0, w_re_abs} + {1'b0, w_im_abs};
    if (w_sum > 18'h07FFF) begin
      o_mag = BAR_MAX;
    end else begin
      o_mag = w_sum[15:0];
    end
  end

endmodule

// File: rtl/spectrum_bar_builder.sv
// spectrum_bar_builder: folds a stream of FFT bins into sixteen bar heights,
// keeps the per-bar maximum of each frame, optionally applies peak-hold with
// decay, and publishes all bars at once with a done qualifier.
// Build option: define SPECTRUM_PEAK_DECAY_EN to enable peak-hold with decay;
// without it the bars follow the current frame directly.
//   clk50      50 MHz clock
//   rst_n      synchronous active-low reset
//   bin_valid  bin presented          bin_ready  bin accepted this cycle
//   bin_idx    bar index of the bin   bin_last   final bin of the frame
//   bin_re/im  signed Q1.15 components
//   f0..f15    published bar heights  done       bars coherent, safe to sample
module spectrum_bar_builder
  import spectrum_pkg::*;
#(
  parameter int unsigned DECAY_SHIFT = 3
) (
  input  logic             clk50,
  input  logic             rst_n,
  input  logic             bin_valid,
  output logic             bin_ready,
  input  logic [3:0]       bin_idx,
  input  logic [15:0]      bin_re,
  input  logic [15:0]      bin_im,
  input  logic             bin_last,
  output logic [BAR_W-1:0] f0,
  output logic [BAR_W-1:0] f1,
  output logic [BAR_W-1:0] f2,
  output logic [BAR_W-1:0] f3,
  output logic [BAR_W-1:0] f4,
  output logic [BAR_W-1:0] f5,
  output logic [BAR_W-1:0] f6,
  output logic [BAR_W-1:0] f7,
  output logic [BAR_W-1:0] f8,
  output logic [BAR_W-1:0] f9,
  output logic [BAR_W-1:0] f10,
  output logic [BAR_W-1:0] f11,
  output logic [BAR_W-1:0] f12,
  output logic [BAR_W-1:0] f13,
  output logic [BAR_W-1:0] f14,
  output logic [BAR_W-1:0] f15,
  output logic             done
);

`ifdef SPECTRUM_PEAK_DECAY_EN
  localparam logic DECAY_EN = 1'b1;
`else
  localparam logic DECAY_EN = 1'b0;
`endif

  spec_state_t      r_state;
  spec_state_t      w_state_nxt;
  logic [BAR_W-1:0] r_mbuf [NUM_BARS];
  logic [BAR_W-1:0] r_hold [NUM_BARS];
  logic [BAR_W-1:0] r_f    [NUM_BARS];
  logic [3:0]       r_idx;
  logic             r_ready;
  logic             r_done;
  logic             r_published;
  logic [BAR_W-1:0] w_mag;
  logic [BAR_W-1:0] w_floor;
  logic [BAR_W-1:0] w_hold_nxt;
  logic             w_xfer;

  bin_magnitude u_mag (
    .i_re  (bin_re),
    .i_im  (bin_im),
    .o_mag (w_mag)
  );

  // A transfer needs the registered ready, which is only high in COLLECT.
  always_comb begin
    w_xfer = bin_valid & r_ready;
  end

  // New held value for the bar being updated: the frame maximum, or the
  // decayed previous hold if that is larger and decay is built in.
  always_comb begin
    if (DECAY_EN) begin
      w_floor = decay_step(r_hold[r_idx], DECAY_SHIFT);
    end else begin
      w_floor = 16'h0000;
    end
    if (r_mbuf[r_idx] > w_floor) begin
      w_hold_nxt = r_mbuf[r_idx];
    end else begin
      w_hold_nxt = w_floor;
    end
  end

  // Frame sequencing: collect bins, sweep the bars, publish, one guard cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      COLLECT: begin
        if (w_xfer && bin_last) begin
          w_state_nxt = UPDATE;
        end else begin
          w_state_nxt = COLLECT;
        end
      end
      UPDATE: begin
        if (r_idx == 4'd15) begin
          w_state_nxt = PUBLISH;
        end else begin
          w_state_nxt = UPDATE;
        end
      end
      PUBLISH: w_state_nxt = GUARD;
      GUARD:   w_state_nxt = COLLECT;
      default: w_state_nxt = COLLECT;
    endcase
  end

  // State, bar buffers and registered handshake/qualifier outputs.
  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      r_state     <= COLLECT;
      r_idx       <= 4'd0;
      r_ready     <= 1'b0;
      r_done      <= 1'b0;
      r_published <= 1'b0;
      for (int i = 0; i < NUM_BARS; i++) begin
        r_mbuf[i] <= 16'h0000;
        r_hold[i] <= 16'h0000;
        r_f[i]    <= 16'h0000;
      end
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == COLLECT);
      // done lags the state by one edge, so it drops the edge after the
      // frame's last bin and returns one edge after GUARD.
      r_done  <= r_published & (r_state == COLLECT);
      case (r_state)
        COLLECT: begin
          if (w_xfer && (w_mag > r_mbuf[bin_idx])) begin
            r_mbuf[bin_idx] <= w_mag;
          end
        end
        UPDATE: begin
          r_hold[r_idx] <= w_hold_nxt;
          r_mbuf[r_idx] <= 16'h0000;
          r_idx         <= r_idx + 4'd1;
        end
        PUBLISH: begin
          for (int i = 0; i < NUM_BARS; i++) begin
            r_f[i] <= r_hold[i];
          end
          r_published <= 1'b1;
        end
        GUARD: begin
          r_idx <= 4'd0;
        end
        default: begin
          r_idx <= 4'd0;
        end
      endcase
    end
  end

  assign bin_ready = r_ready;
  assign done      = r_done;
  assign f0  = r_f[0];
  assign f1  = r_f[1];
  assign f2  = r_f[2];
  assign f3  = r_f[3];
  assign f4  = r_f[4];
  assign f5  = r_f[5];
  assign f6  = r_f[6];
  assign f7  = r_f[7];
  assign f8  = r_f[8];
  assign f9  = r_f[9];
  assign f10 = r_f[10];
  assign f11 = r_f[11];
  assign f12 = r_f[12];
  assign f13 = r_f[13];
  assign f14 = r_f[14];
  assign f15 = r_f[15];

endmodule

// File: doc/spectrum_bar_builder.md
# spectrum_bar_builder

Converts the FFT output stream (one complex bin per handshake) into sixteen stable, non-negative bar heights `f0..f15` with a `done` qualifier for the VGA sync/draw stage. Each frame it takes an approximate magnitude per bin and keeps the largest magnitude per bar. It then applies peak-hold with decay against the previous frame and publishes all sixteen values atomically. It sits between the FFT core and `video_sync_generator`, in the 50 MHz `clk50` domain.

## Interface
- `DECAY_SHIFT`, default 3: per-frame decay is `bar >> DECAY_SHIFT`, with a minimum of 1 when the bar is nonzero.
- `clk50` input, 1 bit: the single clock, 50 MHz.
- `rst_n` input, 1 bit: reset, synchronous and active-low.
- `bin_valid` input, 1 bit: the FFT bin is presented.
- `bin_ready` output, 1 bit: the block accepts a bin. A transfer occurs when `bin_valid && bin_ready`.
- `bin_idx` input, 4 bits: bar index of the bin.
- `bin_re` input, 16 bits: signed real part, Q1.15.
- `bin_im` input, 16 bits: signed imaginary part, Q1.15.
- `bin_last` input, 1 bit: the final bin of the frame, qualified by the transfer.
- `f0..f15` output, 16 bits each: published bar heights, range 0..0x7FFF.
- `done` output, 1 bit: high when `f0..f15` are coherent and safe to sample.

## Operation
- **Magnitude:** `mag = |re| + |im|`, computed in 17 bits, so that |−32768| = 32768. The result saturates to 0x7FFF.
- **States:**
  - COLLECT: `bin_ready`=1. On each transfer, `mbuf[bin_idx] <= max(mbuf[bin_idx], mag)`. A transfer with `bin_last` goes to UPDATE, and that bin is still merged.
  - UPDATE: `bin_ready`=0. Sixteen cycles, one bar per cycle, indices 0..15: `hold[i] <= max(mbuf[i], hold[i] − decay(hold[i]))`, clamped at 0; `mbuf[i] <= 0`. After index 15, go to PUBLISH.
  - PUBLISH: `bin_ready`=0. One cycle: `f_i <= hold[i]` for all i. Next state is GUARD.
  - GUARD: `bin_ready`=0. One cycle, then COLLECT.
- **`done`:**
  - Registered output.
  - 0 from reset until the first PUBLISH completes.
  - After that, 0 in UPDATE, PUBLISH and GUARD, and 1 otherwise.
  - This keeps a slower downstream sampler, which reads `f*` only when `done`=1, away from update edges.
- **Bins:** a bin never received in a frame contributes 0. Repeated indices within a frame keep the maximum. Bin order is free.
- **Flow control:** `bin_valid` while `bin_ready`=0 is not consumed. The upstream holds its data.
- **Reset:** `rst_n`=0 at any edge, including mid-UPDATE, has these effects:
  - State returns to COLLECT.
  - `mbuf`, `hold` and `f0..f15` are set to 0.
  - `done`=0, and `bin_ready`=0 while `rst_n` is low.
  - A partially built frame is discarded.

## Timing
- **Reset values:** `f0..f15`=0, `done`=0, `bin_ready`=0. `bin_ready` goes to 1 on the first edge with `rst_n`=1.
- **Latency:** the edge that accepts `bin_last` is E.
  - UPDATE occupies E+1..E+16.
  - New `f*` are visible after edge E+17.
  - `done` returns to 1 after edge E+19.
  - `bin_ready` returns to 1 after edge E+18.
- **Throughput:** one bin per cycle in COLLECT. The frame overhead is 18 cycles.
- **Stability:** `f*` change only on the PUBLISH edge.

## Configuration
- **`SPECTRUM_PEAK_DECAY_EN` defined:** peak-hold with decay applies as described under Operation.
- **`SPECTRUM_PEAK_DECAY_EN` not defined:**
  - `hold[i] <= mbuf[i]`, and bars follow the current frame directly.
  - `DECAY_SHIFT` is ignored.
  - The latency of UPDATE is unchanged.

## Structure
- **Package `spectrum_pkg`:** contains
  - `NUM_BARS`=16
  - `BAR_W`=16
  - `BAR_MAX`=16'h7FFF
  - the state enum `spec_state_t` {COLLECT, UPDATE, PUBLISH, GUARD}
- **Sub-module `bin_magnitude`:** combinational. It takes `re` and `im` and returns the saturated `mag`. It is shared with the FFT debug path.

## Test plan
- **Reset then single bin:** reset, then a frame with bin 3, re=0x1000, im=−0x0800, `bin_last`. Expect `f3`=0x1800, all other bars 0, `done` 0→1 at E+19.
- **Saturation:** bin 0 with re=0x8000, im=0x8000. Expect `f0`=0x7FFF.
- **Duplicate index:** bin 5 with mag 0x0100, then bin 5 with mag 0x0400, then bin 5 with mag 0x0200. Expect `f5`=0x0400.
- **Decay** (macro on, `DECAY_SHIFT`=3): frame 1 `f7`=0x0800, frame 2 bin 7 absent. Expect `f7`=0x0700, then frame 3 0x0620.
- **Backpressure:** hold `bin_valid` high through UPDATE and PUBLISH. Expect no transfer while `bin_ready`=0, and the held bin is consumed at the first COLLECT cycle.
- **Reset mid-UPDATE:** assert `rst_n`=0 at E+8. Expect all `f*`=0 and `done`=0. The next frame publishes only its own bins.
